fc_stream_loader: RTL and testbench
===================================

Name: fc_stream_loader

Overview:
Host-side front end for the fully connected layer: accepts a byte stream (input vector, then weights, then bias) over a valid/ready handshake and packs it into the flattened fc_in_vec/fc_weights/fc_bias buses. It then fires the layer with a one-cycle fc_en pulse, captures fc_out_vec on fc_valid, and streams actual_output_size result bytes back out over valid/ready. It sits between the DMA/test stream and the FC datapath, driving every FC input and consuming every FC output.

Parameters:
INPUT_SIZE, 128, maximum input length; must match the FC instance.
OUTPUT_SIZE, 10, maximum output length; must match the FC instance.
TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with FC_TIMEOUT_EN.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a job; sampled in IDLE only
cfg_input_size  in  32  job input length, sampled on start
cfg_output_size  in  32  job output length, sampled on start
s_data  in  8  input stream byte
s_valid  in  1  s_data valid
s_ready  out  1  loader accepts s_data
m_data  out  8  result byte
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts m_data
m_last  out  1  final result byte of the job
busy  out  1  high in any state except IDLE
err  out  1  one-cycle pulse: rejected start, or timeout
fc_en  out  1  FC enable, one-cycle pulse
fc_actual_input_size  out  32  latched job input length
fc_actual_output_size  out  32  latched job output length
fc_in_vec  out  INPUT_SIZE*8  packed inputs
fc_weights  out  OUTPUT_SIZE*INPUT_SIZE*8  packed weights
fc_bias  out  OUTPUT_SIZE*8  packed bias
fc_out_vec  in  OUTPUT_SIZE*8  FC result
fc_valid  in  1  FC result valid

Behaviour:
- One clock. Reset is synchronous and active-high; clock port is clk, reset port is rst.
- Reset: state IDLE. All outputs, packed buses and counters are 0.
- States: IDLE, LOAD_IN, LOAD_W, LOAD_B, FIRE, WAIT, DRAIN.
- IDLE: on start, checks both sizes.
  - Rejected if either size is 0 or larger than its parameter: err pulses, state stays IDLE.
  - Accepted: latches both sizes, clears all three packed buses to 0 in that same cycle, goes to LOAD_IN.
- LOAD states: s_ready is 1. A byte transfers when s_valid and s_ready are both 1.
  - LOAD_IN: byte k goes to fc_in_vec[k*8 +: 8], for k = 0 to in-1.
  - LOAD_W: row-major, output o then input i. Byte goes to fc_weights[(o*INPUT_SIZE+i)*8 +: 8]; row stride is always INPUT_SIZE.
  - LOAD_B: byte o goes to fc_bias[o*8 +: 8].
  - Each state advances on the cycle its last byte transfers. s_ready deasserts in the cycle after the final bias byte.
- Unloaded lanes stay 0.
- FIRE: fc_en = 1 for exactly one cycle, then WAIT. fc_en is never asserted in any other state.
- WAIT: on fc_valid, captures fc_out_vec into a result register and goes to DRAIN.
- DRAIN: m_data = result byte j. j advances on each m_valid && m_ready transfer.
  - m_last = 1 on j = out-1.
  - m_data, m_valid and m_last are held stable while m_ready = 0.
  - After the last transfer: IDLE, busy falls.
- s_ready and m_valid are never 1 in the same cycle.
- start outside IDLE is ignored (no err).
- fc_* size and bus outputs hold their values until the next accepted start.
- Reset at any point overrides everything, including mid-load or mid-drain.

Optional Feature:
FC_TIMEOUT_EN
- Defined: a counter runs in WAIT. If fc_valid has not arrived after TIMEOUT_CYCLES cycles, err pulses and the state returns to IDLE with no output.
- Undefined: WAIT blocks indefinitely and no counter logic is synthesized.

Decomposition:
- Shared package fc_pkg:
  - state enum fc_ld_state_t
  - DATA_W = 8
  - SIZE_W = 32
  - helper constant/function for the weight lane offset, o*INPUT_SIZE+i
- One natural sub-module: fc_result_serializer (capture register + DRAIN byte serializer with m_last).

Test Plan:
- in=2, out=1; stream in [3,4], w [2,5], b [1]. Required: exactly one fc_en pulse; m_data=0x1B (27) with m_last=1.
- Wrap: in=1, out=1; in [100], w [2], b [0]. Required: m_data=0xC8 (-56).
- Back-pressure: in=1, out=3, all outputs valid; hold m_ready=0 for 5 cycles per byte. Required: m_data/m_valid stable, 3 bytes in order, m_last only on the third.
- Invalid start: cfg_input_size=0, then cfg_output_size=OUTPUT_SIZE+1. Required: err pulses each time, busy stays 0, s_ready=0.
- Reset mid-load: after 1 of 2 input bytes, assert rst. Required: all outputs 0. A following full job then produces correct results with zeroed unused lanes.
- FC_TIMEOUT_EN: tie fc_valid=0. Required: err pulses TIMEOUT_CYCLES cycles into WAIT, state returns to IDLE, m_valid never asserts.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and constants for the FC stream loader and its result serializer.
package fc_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SIZE_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoadIn,
    StLoadW,
    StLoadB,
    StFire,
    StWait,
    StDrain
  } fc_ld_state_t;

  // Weight lane for output o, input i; the row stride is the full INPUT_SIZE, not the job size.
  function automatic logic [SIZE_W-1:0] fc_w_lane(input logic [SIZE_W-1:0] o,
                                                   input logic [SIZE_W-1:0] i,
                                                   input logic [SIZE_W-1:0] stride);
    return o * stride + i;
  endfunction

endpackage

// File: rtl/fc_result_serializer.sv
// Captures the FC result vector and streams its first i_size bytes out over valid/ready.
module fc_result_serializer
  import fc_pkg::*;
#(
  parameter int unsigned OUTPUT_SIZE = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_capture,
  input  logic [OUTPUT_SIZE*DATA_W-1:0] i_data,
  input  logic [SIZE_W-1:0]             i_size,
  input  logic                          i_ready,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_valid,
  output logic                          o_last,
  output logic                          o_done
);

  logic [OUTPUT_SIZE*DATA_W-1:0] r_result;
  logic [SIZE_W-1:0]             r_j;
  logic                          r_active;
  logic [DATA_W-1:0]             w_byte;
  logic                          w_last;
  logic                          w_xfer;

  assign w_last  = r_active && (r_j == i_size - 32'd1);
  assign w_xfer  = r_active && i_ready;
  assign o_valid = r_active;
  assign o_last  = w_last;
  assign o_done  = w_xfer && w_last;
  assign o_data  = r_active ? w_byte : '0;

  always_comb begin
    w_byte = '0;
    for (int j = 0; j < OUTPUT_SIZE; j++) begin
      if (SIZE_W'(j) == r_j) w_byte = r_result[j*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_j      <= '0;
      r_active <= 1'b0;
    end else if (i_capture) begin
      r_result <= i_data;
      r_j      <= '0;
      r_active <= 1'b1;
    end else if (w_xfer) begin
      if (w_last) begin
        r_j      <= '0;
        r_active <= 1'b0;
      end else begin
        r_j <= r_j + 32'd1;
      end
    end
  end

endmodule

// File: rtl/fc_stream_loader.sv
// Byte-stream front end for the FC layer: load inputs/weights/bias, fire, drain results.
// Optional WAIT watchdog enabled by defining FC_TIMEOUT_EN.
module fc_stream_loader
  import fc_pkg::*;
#(
  parameter int unsigned INPUT_SIZE     = 128,
  parameter int unsigned OUTPUT_SIZE    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [SIZE_W-1:0]                        cfg_input_size,
  input  logic [SIZE_W-1:0]                        cfg_output_size,
  input  logic [DATA_W-1:0]                        s_data,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  output logic [DATA_W-1:0]                        m_data,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic                                     m_last,
  output logic                                     busy,
  output logic                                     err,
  output logic                                     fc_en,
  output logic [SIZE_W-1:0]                        fc_actual_input_size,
  output logic [SIZE_W-1:0]                        fc_actual_output_size,
  output logic [INPUT_SIZE*DATA_W-1:0]             fc_in_vec,
  output logic [OUTPUT_SIZE*INPUT_SIZE*DATA_W-1:0] fc_weights,
  output logic [OUTPUT_SIZE*DATA_W-1:0]            fc_bias,
  input  logic [OUTPUT_SIZE*DATA_W-1:0]            fc_out_vec,
  input  logic                                     fc_valid
);

  fc_ld_state_t r_state, w_state_d;

  logic [SIZE_W-1:0] r_in_size, r_out_size, r_idx, r_row;
  logic [INPUT_SIZE*DATA_W-1:0]             r_in_vec;
  logic [OUTPUT_SIZE*INPUT_SIZE*DATA_W-1:0] r_weights;
  logic [OUTPUT_SIZE*DATA_W-1:0]            r_bias;
  logic              r_err;
  logic              w_err, w_accept, w_capture, w_xfer, w_drain_done;
  logic              w_last_in, w_last_row, w_last_b;
  logic [SIZE_W-1:0] w_lane;

  assign w_xfer     = s_valid && s_ready;
  assign w_last_in  = (r_idx == r_in_size - 32'd1);
  assign w_last_row = (r_row == r_out_size - 32'd1);
  assign w_last_b   = (r_idx == r_out_size - 32'd1);
  assign w_lane     = fc_w_lane(r_row, r_idx, SIZE_W'(INPUT_SIZE));

  assign s_ready = (r_state == StLoadIn) || (r_state == StLoadW) || (r_state == StLoadB);
  assign fc_en   = (r_state == StFire);
  assign busy    = (r_state != StIdle);
  assign err     = r_err;

  assign fc_actual_input_size  = r_in_size;
  assign fc_actual_output_size = r_out_size;
  assign fc_in_vec             = r_in_vec;
  assign fc_weights            = r_weights;
  assign fc_bias               = r_bias;

`ifdef FC_TIMEOUT_EN
  logic [SIZE_W-1:0] r_tmo;
  logic              w_tmo_hit;

  assign w_tmo_hit = (r_tmo == SIZE_W'(TIMEOUT_CYCLES) - 32'd1);

  always_ff @(posedge clk) begin
    if (rst || (r_state != StWait)) r_tmo <= '0;
    else                            r_tmo <= r_tmo + 32'd1;
  end
`else
  logic w_tmo_hit;
  logic w_unused_tmo;

  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    w_state_d = r_state;
    w_err     = 1'b0;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          if ((cfg_input_size == '0) || (cfg_input_size > SIZE_W'(INPUT_SIZE)) ||
              (cfg_output_size == '0) || (cfg_output_size > SIZE_W'(OUTPUT_SIZE))) begin
            w_err = 1'b1;
          end else begin
            w_accept  = 1'b1;
            w_state_d = StLoadIn;
          end
        end
      end
      StLoadIn: if (w_xfer && w_last_in) w_state_d = StLoadW;
      StLoadW:  if (w_xfer && w_last_in && w_last_row) w_state_d = StLoadB;
      StLoadB:  if (w_xfer && w_last_b) w_state_d = StFire;
      StFire:   w_state_d = StWait;
      StWait: begin
        if (fc_valid) begin
          w_capture = 1'b1;
          w_state_d = StDrain;
        end else if (w_tmo_hit) begin
          w_err     = 1'b1;
          w_state_d = StIdle;
        end
      end
      StDrain:  if (w_drain_done) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_size  <= '0;
      r_out_size <= '0;
      r_idx      <= '0;
      r_row      <= '0;
      r_in_vec   <= '0;
      r_weights  <= '0;
      r_bias     <= '0;
    end else if (w_accept) begin
      r_in_size  <= cfg_input_size;
      r_out_size <= cfg_output_size;
      r_idx      <= '0;
      r_row      <= '0;
      r_in_vec   <= '0;
      r_weights  <= '0;
      r_bias     <= '0;
    end else if (w_xfer) begin
      unique case (r_state)
        StLoadIn: begin
          for (int k = 0; k < INPUT_SIZE; k++) begin
            if (SIZE_W'(k) == r_idx) r_in_vec[k*DATA_W +: DATA_W] <= s_data;
          end
          r_idx <= w_last_in ? '0 : r_idx + 32'd1;
        end
        StLoadW: begin
          for (int k = 0; k < OUTPUT_SIZE * INPUT_SIZE; k++) begin
            if (SIZE_W'(k) == w_lane) r_weights[k*DATA_W +: DATA_W] <= s_data;
          end
          if (w_last_in) begin
            r_idx <= '0;
            r_row <= w_last_row ? '0 : r_row + 32'd1;
          end else begin
            r_idx <= r_idx + 32'd1;
          end
        end
        StLoadB: begin
          for (int k = 0; k < OUTPUT_SIZE; k++) begin
            if (SIZE_W'(k) == r_idx) r_bias[k*DATA_W +: DATA_W] <= s_data;
          end
          r_idx <= w_last_b ? '0 : r_idx + 32'd1;
        end
        default: ;
      endcase
    end
  end

  fc_result_serializer #(
    .OUTPUT_SIZE(OUTPUT_SIZE)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .i_capture(w_capture),
    .i_data   (fc_out_vec),
    .i_size   (r_out_size),
    .i_ready  (m_ready),
    .o_data   (m_data),
    .o_valid  (m_valid),
    .o_last   (m_last),
    .o_done   (w_drain_done)
  );

endmodule

// File: tb/tb_fc_stream_loader.sv
// Self-checking bench for fc_stream_loader with a behavioural FC stand-in and result scoreboard.
module tb_fc_stream_loader;

  localparam int IN  = 128;
  localparam int OUT = 10;
  localparam int TMO = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic                   clk, rst, start;
  logic [31:0]            cfg_input_size, cfg_output_size;
  logic [7:0]             s_data;
  logic                   s_valid, s_ready;
  logic [7:0]             m_data;
  logic                   m_valid, m_ready, m_last;
  logic                   busy, err, fc_en;
  logic [31:0]            fc_actual_input_size, fc_actual_output_size;
  logic [IN*8-1:0]        fc_in_vec;
  logic [OUT*IN*8-1:0]    fc_weights;
  logic [OUT*8-1:0]       fc_bias;
  logic [OUT*8-1:0]       fc_out_vec;
  logic                   fc_valid;

  int   vectors = 0;
  int   fails   = 0;
  int   fc_en_cnt = 0;
  bit   fc_stub_en = 1;
  exp_t q[$];

  logic [7:0] t_in [IN];
  logic [7:0] t_w  [OUT][IN];
  logic [7:0] t_b  [OUT];
  logic [7:0] stub_acc;

  fc_stream_loader #(
    .INPUT_SIZE    (IN),
    .OUTPUT_SIZE   (OUT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .cfg_input_size       (cfg_input_size),
    .cfg_output_size      (cfg_output_size),
    .s_data               (s_data),
    .s_valid              (s_valid),
    .s_ready              (s_ready),
    .m_data               (m_data),
    .m_valid              (m_valid),
    .m_ready              (m_ready),
    .m_last               (m_last),
    .busy                 (busy),
    .err                  (err),
    .fc_en                (fc_en),
    .fc_actual_input_size (fc_actual_input_size),
    .fc_actual_output_size(fc_actual_output_size),
    .fc_in_vec            (fc_in_vec),
    .fc_weights           (fc_weights),
    .fc_bias              (fc_bias),
    .fc_out_vec           (fc_out_vec),
    .fc_valid             (fc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (fc_en === 1'b1) fc_en_cnt++;

  // Behavioural FC layer: responds to fc_en a few cycles later, 8-bit wrapping MAC.
  always @(negedge clk) begin
    if (fc_en === 1'b1 && fc_stub_en) begin
      fc_out_vec = '0;
      for (int o = 0; o < OUT; o++) begin
        if (o < fc_actual_output_size) begin
          stub_acc = fc_bias[o*8 +: 8];
          for (int i = 0; i < IN; i++) begin
            if (i < fc_actual_input_size)
              stub_acc = stub_acc + 8'(fc_in_vec[i*8 +: 8] * fc_weights[(o*IN+i)*8 +: 8]);
          end
          fc_out_vec[o*8 +: 8] = stub_acc;
        end
      end
      @(negedge clk);
      @(negedge clk);
      fc_valid = 1'b1;
      @(negedge clk);
      fc_valid = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void clear_stim();
    for (int i = 0; i < IN; i++) t_in[i] = '0;
    for (int o = 0; o < OUT; o++) begin
      t_b[o] = '0;
      for (int i = 0; i < IN; i++) t_w[o][i] = '0;
    end
  endfunction

  task automatic send_byte(input logic [7:0] d);
    int t = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL s_ready_wait: got %b want 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Starts a job, pushes the expected results, streams all bytes; returns at the FIRE cycle.
  task automatic run_job(input int in_n, input int out_n);
    logic [7:0] acc;
    for (int o = 0; o < out_n; o++) begin
      acc = t_b[o];
      for (int i = 0; i < in_n; i++) acc = acc + 8'(t_in[i] * t_w[o][i]);
      q.push_back('{d: acc, last: (o == out_n - 1)});
    end
    @(negedge clk);
    cfg_input_size  = 32'(in_n);
    cfg_output_size = 32'(out_n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < in_n; i++) send_byte(t_in[i]);
    for (int o = 0; o < out_n; o++)
      for (int i = 0; i < in_n; i++) send_byte(t_w[o][i]);
    for (int o = 0; o < out_n; o++) send_byte(t_b[o]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, s_ready, m_valid, m_last, err, fc_en} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000000", {busy, s_ready, m_valid, m_last, err, fc_en});
    end
    vectors++;
    if ({m_data, fc_actual_input_size, fc_actual_output_size} !== '0) begin
      fails++;
      $display("FAIL reset_sizes: got %0h/%0h/%0h want 0", m_data, fc_actual_input_size,
               fc_actual_output_size);
    end
    vectors++;
    if ((|fc_in_vec) !== 1'b0 || (|fc_weights) !== 1'b0 || (|fc_bias) !== 1'b0) begin
      fails++;
      $display("FAIL reset_buses: got nonzero want 0");
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int   c0, t;
    exp_t e;
    clear_stim();
    t_in[0] = 8'd3; t_in[1] = 8'd4; t_w[0][0] = 8'd2; t_w[0][1] = 8'd5; t_b[0] = 8'd1;
    c0 = fc_en_cnt;
    run_job(2, 1);
    vectors++;
    if (s_ready !== 1'b0 || fc_en !== 1'b1) begin
      fails++;
      $display("FAIL fire_cycle: got s_ready=%b fc_en=%b want 0/1", s_ready, fc_en);
    end
    m_ready = 1'b1;
    t = 0;
    while (q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
      if (m_valid === 1'b1) begin
        e = q.pop_front();
        vectors++;
        if (m_data !== 8'h1B || {m_data, m_last} !== {e.d, e.last}) begin
          fails++;
          $display("FAIL basic_result: got %h/%b want 1b/%b", m_data, m_last, e.last);
        end
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    vectors++;
    if (q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: got pending=%0d busy=%b want 0/0", q.size(), busy);
    end
    vectors++;
    if (fc_en_cnt - c0 != 1) begin
      fails++;
      $display("FAIL fc_en_pulses: got %0d want 1", fc_en_cnt - c0);
    end
  endtask

  task automatic test_wrap();
    int   t;
    exp_t e;
    clear_stim();
    t_in[0] = 8'd100; t_w[0][0] = 8'd2; t_b[0] = 8'd0;
    run_job(1, 1);
    m_ready = 1'b1;
    t = 0;
    while (q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
      if (m_valid === 1'b1) begin
        e = q.pop_front();
        vectors++;
        if (m_data !== 8'hC8 || {m_data, m_last} !== {e.d, e.last}) begin
          fails++;
          $display("FAIL wrap_result: got %h/%b want c8/1", m_data, m_last);
        end
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    vectors++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL wrap_drain: got pending=%0d want 0", q.size());
    end
  endtask

  task automatic test_backpressure();
    int         t;
    bit         stable, err_seen;
    logic [7:0] d0;
    logic       l0;
    exp_t       e;
    clear_stim();
    t_in[0] = 8'd1;
    t_w[0][0] = 8'd1; t_w[1][0] = 8'd2; t_w[2][0] = 8'd3;
    t_b[0] = 8'd10; t_b[1] = 8'd20; t_b[2] = 8'd30;
    m_ready = 1'b0;
    run_job(1, 3);
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (m_valid !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      d0 = m_data;
      l0 = m_last;
      stable = 1;
      err_seen = 0;
      for (int c = 0; c < 5; c++) begin
        // A start while draining must be ignored, even with illegal sizes.
        if (k == 0 && c == 0) begin
          cfg_input_size = '0;
          start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        if (err === 1'b1) err_seen = 1;
        if (m_valid !== 1'b1 || m_data !== d0 || m_last !== l0) stable = 0;
      end
      vectors++;
      if (!stable) begin
        fails++;
        $display("FAIL bp_stable[%0d]: got %h/%b/%b want %h/1/%b", k, m_data, m_valid, m_last,
                 d0, l0);
      end
      if (k == 0) begin
        vectors++;
        if (err_seen) begin
          fails++;
          $display("FAIL start_ignored: got err=1 want 0");
        end
      end
      vectors++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL bp_extra_byte[%0d]: got %h want none", k, m_data);
      end else begin
        e = q.pop_front();
        if ({m_data, m_last} !== {e.d, e.last}) begin
          fails++;
          $display("FAIL bp_result[%0d]: got %h/%b want %h/%b", k, m_data, m_last, e.d, e.last);
        end
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    vectors++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_done: got busy=%b m_valid=%b want 0/0", busy, m_valid);
    end
  endtask

  task automatic test_invalid_start();
    logic [31:0] bad_in  [3] = '{32'd0, 32'd1, 32'(IN + 1)};
    logic [31:0] bad_out [3] = '{32'd1, 32'(OUT + 1), 32'd1};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cfg_input_size  = bad_in[k];
      cfg_output_size = bad_out[k];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if ({err, busy, s_ready} !== 3'b100) begin
        fails++;
        $display("FAIL reject[%0d]: got err/busy/s_ready=%b want 100", k, {err, busy, s_ready});
      end
      @(negedge clk);
      vectors++;
      if ({err, busy} !== 2'b00) begin
        fails++;
        $display("FAIL reject_pulse[%0d]: got err/busy=%b want 00", k, {err, busy});
      end
    end
  endtask

  task automatic test_reset_midload();
    int                  t;
    exp_t                e;
    logic [IN*8-1:0]     exp_in;
    logic [OUT*IN*8-1:0] exp_w;
    logic [OUT*8-1:0]    exp_b;
    @(negedge clk);
    cfg_input_size  = 32'd2;
    cfg_output_size = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'd9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy, s_ready, m_valid, err, fc_en} !== 5'b0 || fc_actual_input_size !== '0 ||
        fc_actual_output_size !== '0 || (|fc_in_vec) !== 1'b0 || (|fc_weights) !== 1'b0 ||
        (|fc_bias) !== 1'b0) begin
      fails++;
      $display("FAIL midload_reset: got busy=%b s_ready=%b in0=%h want all 0", busy, s_ready,
               fc_in_vec[7:0]);
    end
    clear_stim();
    t_in[0] = 8'd5; t_in[1] = 8'd6; t_in[2] = 8'd7;
    t_w[0][0] = 8'd1; t_w[0][1] = 8'd2; t_w[0][2] = 8'd3;
    t_w[1][0] = 8'd4; t_w[1][1] = 8'd5; t_w[1][2] = 8'd6;
    t_b[0] = 8'd7; t_b[1] = 8'd8;
    exp_in = '0; exp_w = '0; exp_b = '0;
    for (int i = 0; i < 3; i++) exp_in[i*8 +: 8] = t_in[i];
    for (int o = 0; o < 2; o++) begin
      exp_b[o*8 +: 8] = t_b[o];
      for (int i = 0; i < 3; i++) exp_w[(o*IN+i)*8 +: 8] = t_w[o][i];
    end
    run_job(3, 2);
    vectors++;
    if (fc_in_vec !== exp_in) begin
      fails++;
      $display("FAIL in_vec_pack: got %h want %h", fc_in_vec[31:0], exp_in[31:0]);
    end
    vectors++;
    if (fc_weights !== exp_w) begin
      fails++;
      $display("FAIL weights_pack: got %h want %h", fc_weights[(IN+3)*8-1:IN*8],
               exp_w[(IN+3)*8-1:IN*8]);
    end
    vectors++;
    if (fc_bias !== exp_b || fc_actual_input_size !== 32'd3 || fc_actual_output_size !== 32'd2)
    begin
      fails++;
      $display("FAIL bias_sizes: got %h/%0d/%0d want %h/3/2", fc_bias[15:0],
               fc_actual_input_size, fc_actual_output_size, exp_b[15:0]);
    end
    m_ready = 1'b1;
    t = 0;
    while (q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
      if (m_valid === 1'b1) begin
        e = q.pop_front();
        vectors++;
        if ({m_data, m_last} !== {e.d, e.last}) begin
          fails++;
          $display("FAIL midload_result: got %h/%b want %h/%b", m_data, m_last, e.d, e.last);
        end
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    vectors++;
    if (q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midload_done: got pending=%0d busy=%b want 0/0", q.size(), busy);
    end
  endtask

`ifdef FC_TIMEOUT_EN
  task automatic test_timeout();
    int t;
    bit mv_seen;
    clear_stim();
    t_in[0] = 8'd1; t_w[0][0] = 8'd1;
    fc_stub_en = 0;
    m_ready = 1'b1;
    run_job(1, 1);
    q.delete();
    t = 0;
    mv_seen = 0;
    while (err !== 1'b1 && t < TMO + 20) begin
      @(negedge clk);
      t++;
      if (m_valid === 1'b1) mv_seen = 1;
    end
    vectors++;
    if (t != TMO + 1) begin
      fails++;
      $display("FAIL timeout_latency: got %0d want %0d", t, TMO + 1);
    end
    vectors++;
    if (busy !== 1'b0 || mv_seen) begin
      fails++;
      $display("FAIL timeout_idle: got busy=%b m_valid_seen=%b want 0/0", busy, mv_seen);
    end
    @(negedge clk);
    m_ready = 1'b0;
    fc_stub_en = 1;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; cfg_input_size = '0; cfg_output_size = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    fc_out_vec = '0; fc_valid = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_invalid_start();
    test_reset_midload();
`ifdef FC_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
